// File: rtl/bounded_step_pkg.sv
// Shared mode constants and the range-clamp helper for bounded_step_counter.
package bounded_step_pkg;

  localparam int unsigned MODE_HOLD = 0;
  localparam int unsigned MODE_SAT  = 1;
  localparam int unsigned MODE_WRAP = 2;

  // Widest counter the clamp helper supports; callers zero-extend and truncate.
  localparam int unsigned CLAMP_W = 64;

  function automatic logic [CLAMP_W-1:0] clamp(input logic [CLAMP_W-1:0] value,
                                               input logic [CLAMP_W-1:0] lo,
                                               input logic [CLAMP_W-1:0] hi);
    if (value < lo)      return lo;
    else if (value > hi) return hi;
    else                 return value;
  endfunction

endpackage

// File: rtl/bounded_step_channel.sv
// One bounded up/down counter channel: range check, out-of-range policy, event flags.
// Optional sticky error bit when BOUNDED_STEP_STICKY_ERR_EN is defined.
module bounded_step_channel
  import bounded_step_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = MODE_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             cfg_err,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step,
  input  logic             up,
  input  logic             dn,
  output logic [WIDTH-1:0] q,
  output logic             at_hi,
  output logic             at_lo,
  output logic             ovf,
  output logic             unf
`ifdef BOUNDED_STEP_STICKY_ERR_EN
  ,
  input  logic             err_clr,
  output logic             err_sticky
`endif
);

  localparam int unsigned XW = WIDTH + 1;

  logic [XW-1:0]    q_x, step_x, lo_x, hi_x;
  logic [XW-1:0]    sum, span, up_wrap, dn_wrap;
  logic             wrap_ok, dn_oor;
  logic [WIDTH-1:0] q_nxt;
  logic             ovf_nxt, unf_nxt;

  assign q_x    = XW'(q);
  assign step_x = XW'(step);
  assign lo_x   = XW'(lo);
  assign hi_x   = XW'(hi);

  assign at_hi = (q == hi);
  assign at_lo = (q == lo);

  // All range arithmetic is one bit wider than the counter so nothing wraps internally.
  always_comb begin
    q_nxt   = q;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    sum     = q_x + step_x;
    span    = hi_x - lo_x + XW'(1);
    up_wrap = sum - span;
    dn_wrap = q_x + span - step_x;
    wrap_ok = (step_x <= hi_x - lo_x);
    dn_oor  = (step_x + lo_x) > q_x;
    if (!cfg_err) begin
      if (load) begin
        q_nxt = WIDTH'(clamp(CLAMP_W'(load_val), CLAMP_W'(lo), CLAMP_W'(hi)));
      end else if ((up ^ dn) && (step != '0)) begin
        if (up) begin
          if (sum <= hi_x) begin
            q_nxt = WIDTH'(sum);
          end else begin
            ovf_nxt = 1'b1;
            if (MODE == MODE_SAT)                  q_nxt = hi;
            else if (MODE == MODE_WRAP && wrap_ok) q_nxt = WIDTH'(up_wrap);
          end
        end else begin
          if (!dn_oor) begin
            q_nxt = WIDTH'(q_x - step_x);
          end else begin
            unf_nxt = 1'b1;
            if (MODE == MODE_SAT)                  q_nxt = lo;
            else if (MODE == MODE_WRAP && wrap_ok) q_nxt = WIDTH'(dn_wrap);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= lo;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      q   <= q_nxt;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  end

`ifdef BOUNDED_STEP_STICKY_ERR_EN
  // A new event on the same edge as a clear keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) err_sticky <= 1'b0;
    else     err_sticky <= (err_sticky & ~err_clr) | ovf_nxt | unf_nxt;
  end
`endif

endmodule

// File: rtl/bounded_step_counter.sv
// Multi-channel bounded up/down step counter with hold/saturate/wrap policy.
// Define BOUNDED_STEP_STICKY_ERR_EN to add err_clr / err_sticky.
module bounded_step_counter
  import bounded_step_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MODE     = MODE_HOLD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          lo,
  input  logic [WIDTH-1:0]          hi,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  input  logic [CHANNELS*WIDTH-1:0] step,
  input  logic [CHANNELS-1:0]       up,
  input  logic [CHANNELS-1:0]       dn,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       at_hi,
  output logic [CHANNELS-1:0]       at_lo,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       unf,
  output logic                      cfg_err
`ifdef BOUNDED_STEP_STICKY_ERR_EN
  ,
  input  logic                      err_clr,
  output logic [CHANNELS-1:0]       err_sticky
`endif
);

  // Inverted bounds freeze every channel except for reset.
  assign cfg_err = (hi < lo);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    bounded_step_channel #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .lo         (lo),
      .hi         (hi),
      .cfg_err    (cfg_err),
      .load       (load[i]),
      .load_val   (load_val[i*WIDTH +: WIDTH]),
      .step       (step[i*WIDTH +: WIDTH]),
      .up         (up[i]),
      .dn         (dn[i]),
      .q          (q[i*WIDTH +: WIDTH]),
      .at_hi      (at_hi[i]),
      .at_lo      (at_lo[i]),
      .ovf        (ovf[i]),
      .unf        (unf[i])
`ifdef BOUNDED_STEP_STICKY_ERR_EN
      ,
      .err_clr    (err_clr),
      .err_sticky (err_sticky[i])
`endif
    );
  end

endmodule

// File: tb/tb_bounded_step_counter.sv
// Directed bench: three counters (hold, saturate, wrap) share one stimulus stream.
module tb_bounded_step_counter;

  localparam int unsigned W = 8;
  localparam int unsigned C = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] lo, hi;
  logic [C-1:0] load, up, dn;
  logic [C*W-1:0] load_val, step;

  logic [C*W-1:0] q_h, q_s, q_w;
  logic [C-1:0]   ath_h, ath_s, ath_w, atl_h, atl_s, atl_w;
  logic [C-1:0]   ovf_h, ovf_s, ovf_w, unf_h, unf_s, unf_w;
  logic           ce_h, ce_s, ce_w;
`ifdef BOUNDED_STEP_STICKY_ERR_EN
  logic           err_clr;
  logic [C-1:0]   st_h, st_s, st_w;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bounded_step_counter #(.WIDTH(W), .CHANNELS(C), .MODE(0)) u_hold (
    .clk(clk), .rst(rst), .lo(lo), .hi(hi), .load(load), .load_val(load_val),
    .step(step), .up(up), .dn(dn), .q(q_h), .at_hi(ath_h), .at_lo(atl_h),
    .ovf(ovf_h), .unf(unf_h), .cfg_err(ce_h)
`ifdef BOUNDED_STEP_STICKY_ERR_EN
    , .err_clr(err_clr), .err_sticky(st_h)
`endif
  );

  bounded_step_counter #(.WIDTH(W), .CHANNELS(C), .MODE(1)) u_sat (
    .clk(clk), .rst(rst), .lo(lo), .hi(hi), .load(load), .load_val(load_val),
    .step(step), .up(up), .dn(dn), .q(q_s), .at_hi(ath_s), .at_lo(atl_s),
    .ovf(ovf_s), .unf(unf_s), .cfg_err(ce_s)
`ifdef BOUNDED_STEP_STICKY_ERR_EN
    , .err_clr(err_clr), .err_sticky(st_s)
`endif
  );

  bounded_step_counter #(.WIDTH(W), .CHANNELS(C), .MODE(2)) u_wrap (
    .clk(clk), .rst(rst), .lo(lo), .hi(hi), .load(load), .load_val(load_val),
    .step(step), .up(up), .dn(dn), .q(q_w), .at_hi(ath_w), .at_lo(atl_w),
    .ovf(ovf_w), .unf(unf_w), .cfg_err(ce_w)
`ifdef BOUNDED_STEP_STICKY_ERR_EN
    , .err_clr(err_clr), .err_sticky(st_w)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; lo = 8'd0; hi = 8'd255;
    load = '0; up = '0; dn = '0; load_val = '0; step = '0;
`ifdef BOUNDED_STEP_STICKY_ERR_EN
    err_clr = 1'b0;
`endif
    tick();
    chk("rst_q_hold", 32'(q_h), 32'({8'd0, 8'd0}));
    chk("rst_q_wrap", 32'(q_w), 32'({8'd0, 8'd0}));
    chk("rst_flags",  32'({ovf_h, unf_h, ovf_s, unf_s}), 32'h0);
    chk("rst_at_lo",  32'(atl_h), 32'b11);
    chk("rst_cfg_err", 32'({ce_h, ce_s, ce_w}), 32'h0);
    rst = 1'b0;

    // Hold/saturate/wrap on overflow: ch0 250 + 10
    load = 2'b11; load_val = {8'd7, 8'd250};
    tick();
    load = 2'b00; up = 2'b01; step = {8'd0, 8'd10};
    tick();
    chk("hold_ovf_q",   32'(q_h), 32'({8'd7, 8'd250}));
    chk("hold_ovf_flag", 32'(ovf_h), 32'b01);
    chk("hold_at_hi",   32'(ath_h), 32'b00);
    chk("sat_ovf_q",    32'(q_s), 32'({8'd7, 8'd255}));
    chk("wrap_ovf_q",   32'(q_w), 32'({8'd7, 8'd4}));
    up = 2'b00;
    tick();
    chk("ovf_one_cycle", 32'({ovf_h, ovf_s, ovf_w}), 32'h0);

    // Underflow: ch0 5 - 9
    load = 2'b11; load_val = {8'd100, 8'd5};
    tick();
    load = 2'b00; dn = 2'b01; step = {8'd0, 8'd9};
    tick();
    chk("sat_unf_q",    32'(q_s), 32'({8'd100, 8'd0}));
    chk("sat_unf_flag", 32'(unf_s), 32'b01);
    chk("sat_at_lo",    32'(atl_s), 32'b01);
    chk("hold_unf_q",   32'(q_h), 32'({8'd100, 8'd5}));
    chk("wrap_unf_q",   32'(q_w), 32'({8'd100, 8'd252}));
    tick();
    chk("sat_unf_b2b",  32'(unf_s), 32'b01);
    dn = 2'b00;

    // Landing exactly on hi, then a zero step
    load = 2'b01; load_val = {8'd0, 8'd200};
    tick();
    load = 2'b00; up = 2'b01; step = {8'd0, 8'd55};
    tick();
    chk("bnd_q",      32'(q_h), 32'({8'd100, 8'd255}));
    chk("bnd_no_ovf", 32'({ovf_h, ovf_s, ovf_w}), 32'h0);
    chk("bnd_at_hi",  32'(ath_h), 32'b01);
    up = 2'b00; dn = 2'b01; step = {8'd0, 8'd0};
    tick();
    chk("step0_q",     32'(q_s), 32'({8'd100, 8'd255}));
    chk("step0_flags", 32'({ovf_s, unf_s, ovf_w, unf_w}), 32'h0);

    // Load beats up; up+dn cancels; channels independent
    dn = 2'b00; load = 2'b01; load_val = {8'd0, 8'd77}; up = 2'b11; step = {8'd3, 8'd1};
    tick();
    chk("load_prio_q", 32'(q_h), 32'({8'd103, 8'd77}));
    load = 2'b00; up = 2'b01; dn = 2'b11;
    tick();
    chk("updn_q",     32'(q_w), 32'({8'd100, 8'd77}));
    chk("updn_flags", 32'({ovf_w, unf_w}), 32'h0);
    up = 2'b00; dn = 2'b00;

    // Wrap with lo=10, hi=19; load clamps 250 -> 19
    lo = 8'd10; hi = 8'd19;
    load = 2'b11; load_val = {8'd250, 8'd18};
    tick();
    chk("clamp_load", 32'(q_w), 32'({8'd19, 8'd18}));
    load = 2'b00; up = 2'b01; step = {8'd0, 8'd4};
    tick();
    chk("wrap_q",   32'(q_w), 32'({8'd19, 8'd12}));
    chk("wrap_ovf", 32'(ovf_w), 32'b01);
    chk("hold_q_narrow", 32'(q_h), 32'({8'd19, 8'd18}));
    step = {8'd0, 8'd12};
    tick();
    chk("wrap_big_q",   32'(q_w), 32'({8'd19, 8'd12}));
    chk("wrap_big_ovf", 32'(ovf_w), 32'b01);
    up = 2'b00;
`ifdef BOUNDED_STEP_STICKY_ERR_EN
    chk("sticky_set", 32'(st_w), 32'b01);
`endif

    // Mid-sequence reset with lo=3
    lo = 8'd3; hi = 8'd255; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst3_hold", 32'(q_h), 32'({8'd3, 8'd3}));
    chk("rst3_sat",  32'(q_s), 32'({8'd3, 8'd3}));
    chk("rst3_flags", 32'({ovf_w, unf_w, ovf_s, unf_s}), 32'h0);
`ifdef BOUNDED_STEP_STICKY_ERR_EN
    chk("rst3_sticky", 32'({st_h, st_s, st_w}), 32'h0);
`endif

    // Inverted bounds freeze everything except reset
    lo = 8'd9; hi = 8'd4;
    #1;
    chk("cfg_err", 32'({ce_h, ce_s, ce_w}), 32'b111);
    up = 2'b11; load = 2'b10; load_val = {8'd50, 8'd50}; step = {8'd1, 8'd1};
    tick();
    chk("cfg_frozen_q",   32'(q_s), 32'({8'd3, 8'd3}));
    chk("cfg_frozen_ovf", 32'({ovf_h, ovf_s, ovf_w}), 32'h0);
    up = 2'b00; load = 2'b00; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("cfg_rst_q",  32'(q_h), 32'({8'd9, 8'd9}));
    chk("cfg_rst_lo", 32'(atl_h), 32'b11);

`ifdef BOUNDED_STEP_STICKY_ERR_EN
    // Sticky set beats a same-edge clear
    lo = 8'd0; hi = 8'd255; load = 2'b01; load_val = {8'd0, 8'd255};
    tick();
    load = 2'b00; up = 2'b01; step = {8'd0, 8'd1};
    tick();
    chk("sticky_hold", 32'(st_h), 32'b01);
    err_clr = 1'b1;
    tick();
    chk("sticky_set_wins", 32'(st_h), 32'b01);
    up = 2'b00;
    tick();
    chk("sticky_clr", 32'(st_h), 32'b00);
    err_clr = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bounded_step_counter.md
# bounded_step_counter

Multi-channel, parametrised up/down step counter with programmable lower/upper bounds and a selectable out-of-range policy: hold, saturate or wrap. It generalises the team's single 8-bit overflow-rejecting up/down counter to N independent channels of arbitrary width, and adds:
- out-of-range event flags
- bound-reached status
- a compile-time sticky error register

It sits in the datapath wherever a bounded accumulator or position counter is needed (step sequencers, address walkers, level meters).

## Interface
- WIDTH, 8, counter width in bits (≥ 2)
- CHANNELS, 4, number of independent counters (≥ 1)
- MODE, 0, out-of-range policy: 0 = hold, 1 = saturate, 2 = wrap
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- lo  in  WIDTH  lower bound, shared by all channels
- hi  in  WIDTH  upper bound, shared by all channels
- load  in  CHANNELS  per-channel load strobe
- load_val  in  CHANNELS*WIDTH  per-channel load value; channel i at bits [i*WIDTH +: WIDTH]
- step  in  CHANNELS*WIDTH  per-channel step magnitude, unsigned
- up  in  CHANNELS  per-channel increment request
- dn  in  CHANNELS  per-channel decrement request
- q  out  CHANNELS*WIDTH  counter values
- at_hi  out  CHANNELS  combinational: q == hi
- at_lo  out  CHANNELS  combinational: q == lo
- ovf  out  CHANNELS  registered one-cycle pulse: an up op exceeded hi
- unf  out  CHANNELS  registered one-cycle pulse: a dn op went below lo
- cfg_err  out  1  combinational: hi < lo
- err_clr, err_sticky: see Configuration

## Operation
- Per-channel priority each edge: rst > load > (up XOR dn) > idle.
- rst: all q <= lo (sampled that edge); ovf, unf <= 0.
- load: q <= load_val clamped into [lo, hi]; no flag raised.
- up and dn both high: no change, no flag.
- up: compute sum = q + step in WIDTH+1 bits.
  - sum ≤ hi: q <= sum.
  - sum > hi: ovf pulses. Then, by mode:
    - hold: q unchanged.
    - saturate: q <= hi.
    - wrap: q <= sum − (hi − lo + 1), if step ≤ hi − lo; otherwise q is held.
- dn: out of range when step > q − lo.
  - Not out of range: q <= q − step.
  - Out of range: unf pulses. Then, by mode:
    - hold: q unchanged.
    - saturate: q <= lo.
    - wrap: q <= q − step + (hi − lo + 1), if step ≤ hi − lo; otherwise q is held.
- Landing exactly on hi or lo is legal and raises no flag.
- step = 0 is a legal no-op and raises no flag.
- cfg_err = 1 blocks all state changes:
  - load and up/dn are ignored.
  - rst still sets q <= lo.
- Intermediate arithmetic is WIDTH+1 bits, so no wrap-around occurs inside the datapath.

## Timing
- Latency 1: an op sampled at edge k appears on q after edge k.
- ovf/unf are asserted for exactly the one cycle following the edge that applied the offending op; consecutive offending ops give back-to-back pulses.
- at_hi, at_lo and cfg_err follow q, hi, lo combinationally, with no extra latency.
- A bounds change takes effect on the next op. Existing q values outside the new bounds are not corrected until the next load or op.
- Reset values: q = lo, ovf = 0, unf = 0, err_sticky = 0.

## Configuration
- Macro: BOUNDED_STEP_STICKY_ERR_EN.
- Defined:
  - Adds input err_clr (1 bit) and output err_sticky (CHANNELS bits).
  - err_sticky[i] sets on ovf[i] or unf[i] and holds until err_clr or rst.
  - If err_clr and a new event occur on the same edge, the set wins.
- Undefined: neither port exists; no sticky state.

## Structure
- Package bounded_step_pkg holds:
  - Mode constants MODE_HOLD = 0, MODE_SAT = 1, MODE_WRAP = 2.
  - A function clamp(value, lo, hi).
- Sub-module bounded_step_channel holds one channel's counter, range check and flag logic.
- The top level generates CHANNELS instances, plus the shared cfg_err compare.

## Test plan
Unless stated otherwise: WIDTH = 8, CHANNELS = 2, lo = 0, hi = 255.
- Hold mode: load 250, then up with step 10 -> q stays 250, ovf = 1 for one cycle, at_hi = 0.
- Saturate mode: q = 5, dn with step 9 -> q = 0, unf pulses, at_lo = 1.
- Wrap mode, lo = 10, hi = 19: q = 18, up with step 4 -> q = 12 and ovf pulses. Then step 12 -> q held and ovf pulses.
- Boundary: q = 200, up with step 55 -> q = 255, no ovf, at_hi = 1. Then dn with step 0 -> no change, no flag.
- Simultaneous requests: load = 1 with up = 1 -> q = clamped load_val. up = dn = 1 -> q unchanged. Channel 0 and channel 1 must act independently in the same cycle.
- Reset and config error:
  - rst mid-sequence with lo = 3 -> q = 3 on all channels, flags 0, err_sticky cleared (macro defined).
  - lo = 9, hi = 4 -> cfg_err = 1 and ups are ignored.
